// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester-side and FIFO-write-side signal bundle for fifo_wr_arbiter.
//   i_req     : per-lane request, bit k for lane k
//   i_data    : per-lane write words, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_gnt     : combinational one-hot grant (lane word accepted at this edge)
//   i_full    : FIFO full flag (backpressure)
//   o_wr_en   : registered FIFO write enable
//   o_wr_data : registered FIFO write data
//   o_gnt_id  : registered index of the lane that owns o_wr_data
// Modports: slave = arbiter side, master = requesters + FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 4
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
  logic [NUM_REQ-1:0]            o_gnt;
  logic                          i_full;
  logic                          o_wr_en;
  logic [DATA_WIDTH-1:0]         o_wr_data;
  logic [ID_W-1:0]               o_gnt_id;

  modport slave (
    input  i_req,
    input  i_data,
    input  i_full,
    output o_gnt,
    output o_wr_en,
    output o_wr_data,
    output o_gnt_id
  );

  modport master (
    output i_req,
    output i_data,
    output i_full,
    input  o_gnt,
    input  o_wr_en,
    input  o_wr_data,
    input  o_gnt_id
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ
// requesters, funnelled through a one-entry valid/ready output register
// (valid = o_wr_en, ready = !i_full).
//
// Ports:
//   i_clk  : write-domain clock
//   i_rstn : synchronous active-low reset
//   bus    : fifo_wr_arbiter_if.slave (i_req, i_data, i_full in; o_gnt, o_wr_en,
//            o_wr_data, o_gnt_id out). o_gnt is combinational, the rest registered.
//
// Build option: define FIFO_WR_ARB_LOCK_EN to let a burst owner keep priority for
// up to MAX_BURST consecutive grants. Without it, arbitration is pure per-beat
// round robin and MAX_BURST has no effect.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

`ifdef FIFO_WR_ARB_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  // Registered state
  logic [0:0]            state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [ID_W-1:0]       last_q,    last_d;
  logic                  wr_en_q,   wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ID_W-1:0]       gnt_id_q,  gnt_id_d;

  // Arbitration terms
  logic                  stage_free_c;
  logic [ID_W-1:0]       cand_c;
  logic                  rr_found_c;
  logic [ID_W-1:0]       rr_idx_c;
  logic                  lock_hold_c;
  logic [ID_W-1:0]       sel_idx_c;
  logic                  sel_valid_c;
  logic                  gnt_fire_c;

  logic [DATA_WIDTH-1:0] lane_data [NUM_REQ];

  // Unpack the flat data bus into per-lane words
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_data[g] = bus.i_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Stage can accept a new word if empty or being drained this edge
  assign stage_free_c = !wr_en_q || !bus.i_full;

  // Round-robin search starting just after the last granted lane
  always_comb begin
    rr_found_c = 1'b0;
    rr_idx_c   = '0;
    cand_c     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = ID_W'((32'(last_q) + i) % NUM_REQ);
      if (!rr_found_c && bus.i_req[cand_c]) begin
        rr_found_c = 1'b1;
        rr_idx_c   = cand_c;
      end
    end
  end

  // Burst owner keeps priority while requesting and below the beat limit;
  // once the limit is hit the round-robin search (from owner+1) takes over.
  always_comb begin
    lock_hold_c = LOCK_EN && (state_q == BURST) && bus.i_req[last_q] &&
                  (cnt_q < CNT_W'(MAX_BURST));
    sel_idx_c   = lock_hold_c ? last_q : rr_idx_c;
    sel_valid_c = lock_hold_c || rr_found_c;
    gnt_fire_c  = i_rstn && stage_free_c && sel_valid_c;
  end

  assign bus.o_gnt = gnt_fire_c ? (NUM_REQ'(1) << sel_idx_c) : '0;

  // Next-state: burst FSM, beat counter, round-robin pointer and output stage
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    gnt_id_d  = gnt_id_q;

    // A stalled stage freezes everything, including the FSM and counter.
    if (stage_free_c) begin
      if (gnt_fire_c) begin
        wr_en_d   = 1'b1;
        wr_data_d = lane_data[sel_idx_c];
        gnt_id_d  = sel_idx_c;
        last_d    = sel_idx_c;
        state_d   = BURST;
        // A new owner (after a drop or a finished burst) restarts at 1 in the
        // same edge, so the IDLE pass-through costs no bubble.
        cnt_d     = lock_hold_c ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
      end else begin
        wr_en_d   = 1'b0;
        state_d   = IDLE;
        cnt_d     = '0;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= ID_W'(NUM_REQ - 1);
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      gnt_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      gnt_id_q  <= gnt_id_d;
    end
  end

  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_gnt_id  = gnt_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench for fifo_wr_arbiter against a
// behavioural round-robin / burst-lock model with a write-order scoreboard.
module tb_fifo_wr_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 4;
  localparam int MAXB = 4;
  localparam int IDW  = $clog2(NR);
  localparam int DWT  = NR * DW;

`ifdef FIFO_WR_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAXB)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: last granted lane, consecutive beats of current owner,
  // contents of the output stage, and words granted but not yet written.
  int m_last;
  int m_run;
  bit m_valid;
  int m_data;
  int m_id;
  int exp_q[$];
  int model_writes;
  int dut_writes;

  function automatic void model_reset();
    m_last  = NR - 1;
    m_run   = 0;
    m_valid = 1'b0;
    m_data  = 0;
    m_id    = 0;
    exp_q.delete();
  endfunction

  // Lane the spec says wins this cycle, or -1 for no grant
  function automatic int model_pick(input logic rst_n, input logic [NR-1:0] req,
                                    input logic full);
    int idx;
    if (!rst_n || (m_valid && full) || req == '0) return -1;
    if (LOCK && m_run > 0 && m_run < MAXB && req[IDW'(m_last)]) return m_last;
    for (int i = 1; i <= NR; i++) begin
      idx = (m_last + i) % NR;
      if (req[IDW'(idx)]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int lane);
    if (lane < 0) return '0;
    return NR'(1) << lane;
  endfunction

  function automatic int lane_word(input logic [DWT-1:0] d, input int lane);
    return int'(DW'(d >> (lane * DW)));
  endfunction

  // Apply the effect of the coming clock edge to the model
  task automatic commit(input int lane);
    if (!rstn) begin
      model_reset();
      return;
    end
    if (m_valid && !bus.i_full) begin
      void'(exp_q.pop_front());
      model_writes++;
    end
    if (!(m_valid && bus.i_full)) begin
      if (lane >= 0) begin
        m_run   = (LOCK && m_run > 0 && m_run < MAXB && lane == m_last) ? m_run + 1 : 1;
        m_last  = lane;
        m_valid = 1'b1;
        m_id    = lane;
        m_data  = lane_word(bus.i_data, lane);
        exp_q.push_back(m_data);
      end else begin
        m_valid = 1'b0;
        m_run   = 0;
      end
    end
  endtask

  // Drive inputs just after the falling edge and let combinational logic settle
  task automatic drive(input logic rst_n, input logic [NR-1:0] req, input logic full,
                       input logic [DWT-1:0] data);
    @(negedge clk);
    rstn       = rst_n;
    bus.i_req  = req;
    bus.i_full = full;
    bus.i_data = data;
    #1;
  endtask

  task automatic test_reset();
    int lane;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'b1111, 1'b0, DWT'($urandom));
      lane = model_pick(rstn, bus.i_req, bus.i_full);
      total++;
      if (bus.o_gnt !== '0) begin
        bad++;
        $display("FAIL reset_gnt cyc=%0d got=%b exp=0000", c, bus.o_gnt);
      end
      commit(lane);
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'b0000, 1'b0, DWT'($urandom));
      lane = model_pick(rstn, bus.i_req, bus.i_full);
      total++;
      if ({bus.o_gnt, bus.o_wr_en, bus.o_wr_data, bus.o_gnt_id} !== '0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got gnt=%b en=%b data=%h id=%0d exp all zero",
                 c, bus.o_gnt, bus.o_wr_en, bus.o_wr_data, bus.o_gnt_id);
      end
      commit(lane);
    end
  endtask

  task automatic test_round_robin();
    int lane;
    for (int c = 0; c < 14; c++) begin
      drive(1'b1, (c < 12) ? 4'b1111 : 4'b0000, 1'b0, 16'h4321);
      lane = model_pick(rstn, bus.i_req, bus.i_full);
      total++;
      if (bus.o_gnt !== onehot(lane)) begin
        bad++;
        $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, bus.o_gnt, onehot(lane));
      end
      total++;
      if ({bus.o_wr_en, bus.o_wr_data, bus.o_gnt_id} !== {m_valid, DW'(m_data), IDW'(m_id)}) begin
        bad++;
        $display("FAIL rr_stage cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, bus.o_wr_en,
                 bus.o_wr_data, bus.o_gnt_id, m_valid, DW'(m_data), m_id);
      end
      commit(lane);
    end
  endtask

  task automatic test_backpressure();
    int lane;
    logic full;
    for (int c = 0; c < 9; c++) begin
      full = (c >= 1 && c <= 3);
      drive(1'b1, (c < 7) ? 4'b0101 : 4'b0000, full, DWT'($urandom));
      lane = model_pick(rstn, bus.i_req, bus.i_full);
      total++;
      if (bus.o_gnt !== onehot(lane)) begin
        bad++;
        $display("FAIL bp_gnt cyc=%0d got=%b exp=%b", c, bus.o_gnt, onehot(lane));
      end
      total++;
      if ({bus.o_wr_en, bus.o_wr_data, bus.o_gnt_id} !== {m_valid, DW'(m_data), IDW'(m_id)}) begin
        bad++;
        $display("FAIL bp_stage cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, bus.o_wr_en,
                 bus.o_wr_data, bus.o_gnt_id, m_valid, DW'(m_data), m_id);
      end
      commit(lane);
    end
  endtask

  task automatic test_lock_burst();
    int lane;
    for (int c = 0; c < 13; c++) begin
      drive(1'b1, (c < 12) ? 4'b0011 : 4'b0000, 1'b0, DWT'($urandom));
      lane = model_pick(rstn, bus.i_req, bus.i_full);
      total++;
      if (bus.o_gnt !== onehot(lane)) begin
        bad++;
        $display("FAIL burst_gnt cyc=%0d got=%b exp=%b", c, bus.o_gnt, onehot(lane));
      end
      total++;
      if ({bus.o_wr_en, bus.o_wr_data, bus.o_gnt_id} !== {m_valid, DW'(m_data), IDW'(m_id)}) begin
        bad++;
        $display("FAIL burst_stage cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, bus.o_wr_en,
                 bus.o_wr_data, bus.o_gnt_id, m_valid, DW'(m_data), m_id);
      end
      commit(lane);
    end
  endtask

  task automatic test_owner_drop();
    int lane;
    logic [NR-1:0] req_seq [7];
    req_seq = '{4'b0100, 4'b1100, 4'b1000, 4'b1000, 4'b1010, 4'b0000, 4'b0000};
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, req_seq[c], 1'b0, DWT'($urandom));
      lane = model_pick(rstn, bus.i_req, bus.i_full);
      total++;
      if (bus.o_gnt !== onehot(lane)) begin
        bad++;
        $display("FAIL drop_gnt cyc=%0d got=%b exp=%b", c, bus.o_gnt, onehot(lane));
      end
      total++;
      if ({bus.o_wr_en, bus.o_wr_data, bus.o_gnt_id} !== {m_valid, DW'(m_data), IDW'(m_id)}) begin
        bad++;
        $display("FAIL drop_stage cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, bus.o_wr_en,
                 bus.o_wr_data, bus.o_gnt_id, m_valid, DW'(m_data), m_id);
      end
      commit(lane);
    end
  endtask

  task automatic test_random();
    int lane;
    logic [NR-1:0] req;
    logic full;
    model_writes = 0;
    dut_writes   = 0;
    for (int c = 0; c < 404; c++) begin
      req  = ($urandom_range(0, 4) == 0) ? '0 : NR'($urandom_range(0, 15));
      full = ($urandom_range(0, 3) == 0);
      if (c >= 400) begin
        req  = '0;
        full = 1'b0;
      end
      drive(1'b1, req, full, DWT'($urandom));
      lane = model_pick(rstn, bus.i_req, bus.i_full);
      total++;
      if (bus.o_gnt !== onehot(lane)) begin
        bad++;
        $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, bus.o_gnt, onehot(lane));
      end
      total++;
      if ({bus.o_wr_en, bus.o_wr_data, bus.o_gnt_id} !== {m_valid, DW'(m_data), IDW'(m_id)}) begin
        bad++;
        $display("FAIL rand_stage cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, bus.o_wr_en,
                 bus.o_wr_data, bus.o_gnt_id, m_valid, DW'(m_data), m_id);
      end
      if (bus.o_wr_en && !bus.i_full) begin
        dut_writes++;
        total++;
        if (exp_q.size() == 0 || bus.o_wr_data !== DW'(exp_q[0])) begin
          bad++;
          $display("FAIL rand_write_order cyc=%0d got=%h exp=%h pending=%0d", c,
                   bus.o_wr_data, (exp_q.size() == 0) ? 0 : exp_q[0], exp_q.size());
        end
      end
      commit(lane);
    end
    total++;
    if (dut_writes != model_writes || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_write_count got=%0d exp=%0d leftover=%0d", dut_writes,
               model_writes, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int lane;
    logic rst_n;
    for (int c = 0; c < 7; c++) begin
      rst_n = (c != 3);
      drive(rst_n, 4'b1111, 1'b0, DWT'($urandom));
      lane = model_pick(rstn, bus.i_req, bus.i_full);
      total++;
      if (bus.o_gnt !== onehot(lane)) begin
        bad++;
        $display("FAIL mrst_gnt cyc=%0d got=%b exp=%b", c, bus.o_gnt, onehot(lane));
      end
      total++;
      if ({bus.o_wr_en, bus.o_wr_data, bus.o_gnt_id} !== {m_valid, DW'(m_data), IDW'(m_id)}) begin
        bad++;
        $display("FAIL mrst_stage cyc=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, bus.o_wr_en,
                 bus.o_wr_data, bus.o_gnt_id, m_valid, DW'(m_data), m_id);
      end
      if (c == 4) begin
        total++;
        if (bus.o_wr_en !== 1'b0 || bus.o_gnt !== 4'b0001) begin
          bad++;
          $display("FAIL mrst_after got en=%b gnt=%b exp en=0 gnt=0001", bus.o_wr_en, bus.o_gnt);
        end
      end
      commit(lane);
    end
  endtask

  initial begin
    model_reset();
    model_writes = 0;
    dut_writes   = 0;
    bus.i_req    = '0;
    bus.i_full   = 1'b0;
    bus.i_data   = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_lock_burst();
    test_owner_drop();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
